hd44780_cmd_queue: RTL

//  Upstream feeder for hd44780_bytesender: buffers {rs,byte} LCD writes in a FIFO, then drains one at a

---
 rtl/hd44780_cmd_queue_pkg.sv | 22 ++
 rtl/hd44780_cmd_queue_if.sv | 28 ++
 rtl/hd44780_cmd_fifo.sv | 62 ++++++
 rtl/hd44780_cmd_queue.sv | 106 ++++++++++
 4 files changed

// File: rtl/hd44780_cmd_queue_pkg.sv
// Shared types and default timing constants for the HD44780 command queue.
// Entries are {rs, byte}; the delay defaults assume a 48 MHz clock.
package hd44780_cmd_queue_pkg;

   localparam int H4_DELAY_53US   = 2544;
   localparam int H4_DELAY_1P52MS = 72960;

   localparam int CQ_DEPTH      = 16;
   localparam int CQ_ADDR_BITS  = 4;
   localparam int CQ_TIMER_BITS = 17;

   typedef struct packed {
      logic       rs;
      logic [7:0] data;
   } lcd_entry_t;

   // Clear display (0x01) and return home (0x02/0x03) need the long execution delay.
   function automatic logic isLongCmd(lcd_entry_t e);
      return (e.rs == 1'b0) && (e.data[7:2] == 6'b000000) && (e.data != 8'h00);
   endfunction

endpackage

// File: rtl/hd44780_cmd_queue_if.sv
// Host push port plus bytesender drain port of the HD44780 command queue.
// The slave modport is the queue itself; the master side is the host/bytesender.
interface hd44780_cmd_queue_if #(parameter int ADDR_BITS = 4);

   logic                 STB_I;
   logic                 i_rs;
   logic [7:0]           i_data;
   logic                 o_full;
   logic                 o_empty;
   logic [ADDR_BITS:0]   o_count;
   logic                 o_ovf;
   logic                 o_busy;
   logic                 o_bs_stb;
   logic                 o_bs_rs;
   logic [7:0]           o_bs_data;
   logic                 i_bs_busy;

   modport slave (
      input  STB_I, i_rs, i_data, i_bs_busy,
      output o_full, o_empty, o_count, o_ovf, o_busy, o_bs_stb, o_bs_rs, o_bs_data
   );

   modport master (
      output STB_I, i_rs, i_data, i_bs_busy,
      input  o_full, o_empty, o_count, o_ovf, o_busy, o_bs_stb, o_bs_rs, o_bs_data
   );

endinterface

// File: rtl/hd44780_cmd_fifo.sv
// Synchronous show-ahead FIFO of {rs, byte} entries with occupancy count.
// Push is refused when full and pop when empty, so callers may strobe freely.
module hd44780_cmd_fifo
   import hd44780_cmd_queue_pkg::*;
#(
   parameter int DEPTH     = CQ_DEPTH,
   parameter int ADDR_BITS = CQ_ADDR_BITS
) (
   input  logic               CLK_I,
   input  logic               RST_N_I,
   input  logic               i_push,
   input  logic               i_pop,
   input  lcd_entry_t         i_wdata,
   output lcd_entry_t         o_rdata,
   output logic               o_full,
   output logic               o_empty,
   output logic [ADDR_BITS:0] o_count
);

   localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

   lcd_entry_t             r_mem [DEPTH];
   logic [ADDR_BITS-1:0]   r_wrPtr;
   logic [ADDR_BITS-1:0]   r_rdPtr;
   logic [ADDR_BITS:0]     r_count;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_push;
   logic                   w_pop;

   assign w_full  = (r_count == FULL_COUNT);
   assign w_empty = (r_count == '0);
   assign w_push  = i_push & ~w_full;
   assign w_pop   = i_pop & ~w_empty;

   always_ff @(posedge CLK_I) begin
      if (w_push) r_mem[r_wrPtr] <= i_wdata;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rdPtr];
   assign o_full  = w_full;
   assign o_empty = w_empty;
   assign o_count = r_count;

endmodule

// File: rtl/hd44780_cmd_queue.sv
// Buffers host LCD writes and drains them one at a time into the bytesender,
// inserting the HD44780 execution delay (long after clear/home) between writes.
module hd44780_cmd_queue
   import hd44780_cmd_queue_pkg::*;
#(
   parameter int DEPTH      = CQ_DEPTH,
   parameter int ADDR_BITS  = CQ_ADDR_BITS,
   parameter int DLY_SHORT  = H4_DELAY_53US,
   parameter int DLY_LONG   = H4_DELAY_1P52MS,
   parameter int TIMER_BITS = CQ_TIMER_BITS
) (
   input  logic              CLK_I,
   input  logic              RST_N_I,
   hd44780_cmd_queue_if.slave bus
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_STROBE  = 3'd1;
   localparam logic [2:0] ST_WAIT_HI = 3'd2;
   localparam logic [2:0] ST_WAIT_LO = 3'd3;
   localparam logic [2:0] ST_DELAY   = 3'd4;

   localparam logic [TIMER_BITS-1:0] T_SHORT = TIMER_BITS'(DLY_SHORT);
   localparam logic [TIMER_BITS-1:0] T_LONG  = TIMER_BITS'(DLY_LONG);

   logic [2:0]            r_state;
   logic                  r_bsRs;
   logic [7:0]            r_bsData;
   logic                  r_long;
   logic                  r_ovf;
   logic [TIMER_BITS-1:0] r_timer;
   lcd_entry_t            w_head;
   lcd_entry_t            w_wdata;
   logic                  w_full;
   logic                  w_empty;
   logic [ADDR_BITS:0]    w_count;
   logic                  w_pop;

   assign w_wdata = {bus.i_rs, bus.i_data};
   assign w_pop   = (r_state == ST_IDLE) & ~w_empty & ~bus.i_bs_busy;

   hd44780_cmd_fifo #(
      .DEPTH     (DEPTH),
      .ADDR_BITS (ADDR_BITS)
   ) u_fifo (
      .CLK_I   (CLK_I),
      .RST_N_I (RST_N_I),
      .i_push  (bus.STB_I),
      .i_pop   (w_pop),
      .i_wdata (w_wdata),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) r_ovf <= 1'b0;
      else if (bus.STB_I & w_full) r_ovf <= 1'b1;
   end

   // Drain FSM: the latched byte stays on o_bs_data until the next pop.
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         r_state  <= ST_IDLE;
         r_bsRs   <= 1'b0;
         r_bsData <= 8'h00;
         r_long   <= 1'b0;
         r_timer  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_bsRs   <= w_head.rs;
                  r_bsData <= w_head.data;
                  r_long   <= isLongCmd(w_head);
                  r_state  <= ST_STROBE;
               end
            end
            ST_STROBE:  r_state <= ST_WAIT_HI;
            ST_WAIT_HI: if (bus.i_bs_busy) r_state <= ST_WAIT_LO;
            ST_WAIT_LO: begin
               if (!bus.i_bs_busy) begin
                  r_timer <= r_long ? T_LONG : T_SHORT;
                  r_state <= ST_DELAY;
               end
            end
            ST_DELAY: begin
               r_timer <= r_timer - 1'b1;
               if (r_timer == TIMER_BITS'(1)) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.o_bs_stb  = (r_state == ST_STROBE);
   assign bus.o_bs_rs   = r_bsRs;
   assign bus.o_bs_data = r_bsData;
   assign bus.o_full    = w_full;
   assign bus.o_empty   = w_empty;
   assign bus.o_count   = w_count;
   assign bus.o_ovf     = r_ovf;
   assign bus.o_busy    = ~w_empty | (r_state != ST_IDLE);

endmodule
